// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// inst_fetch_ctrl: sram-like instruction fetch with a 2-entry decode buffer. Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        ds_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] C_FULL = FIFO_DEPTH[1:0];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;

  logic        pop;
  logic        push;
  logic [1:0]  wpos;
  logic [31:0] br_pc;

  always_comb begin
    pop   = (count_q != 2'd0) && ds_ready;
    push  = (state_q == S_WAIT) && inst_data_ok && !cancel_q && !br_valid;
    wpos  = count_q - {1'b0, pop};
    br_pc = br_target & 32'hFFFF_FFFC;

    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    cancel_d  = cancel_q;
    count_d   = count_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;

    // A redirect flushes the buffer outright; any same-cycle pop is moot.
    if (br_valid) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q - {1'b0, pop} + {1'b0, push};
      if (pop && (count_q == 2'd2)) begin
        e0_pc_d   = e1_pc_q;
        e0_inst_d = e1_inst_q;
      end
      if (push) begin
        if (wpos == 2'd0) begin
          e0_pc_d   = req_pc_q;
          e0_inst_d = inst_rdata;
        end else begin
          e1_pc_d   = req_pc_q;
          e1_inst_d = inst_rdata;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (br_valid) pc_d = br_pc;
        if (count_d < C_FULL) state_d = S_REQ;
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          if (br_valid) begin
            pc_d     = br_pc;
            cancel_d = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (br_valid) begin
          pc_d = br_pc;
        end
      end
      S_WAIT: begin
        if (br_valid) pc_d = br_pc;
        // The outstanding slot is freed here, so only room after push/pop matters.
        if (inst_data_ok) begin
          cancel_d = 1'b0;
          state_d  = (br_valid || (count_d < C_FULL)) ? S_REQ : S_IDLE;
        end else if (br_valid) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= 32'd0;
      cancel_q  <= 1'b0;
      count_q   <= 2'd0;
      e0_pc_q   <= 32'd0;
      e0_inst_q <= 32'd0;
      e1_pc_q   <= 32'd0;
      e1_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      cancel_q  <= cancel_d;
      count_q   <= count_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
    end
  end

  assign inst_req   = (state_q == S_REQ);
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_addr  = {pc_q[31:2], 2'b00};
  assign inst_wdata = 32'd0;
  assign fs_valid   = (count_q != 2'd0);
  assign fs_pc      = e0_pc_q;
  assign fs_inst    = e0_inst_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ============================================================================
// tb_inst_fetch_ctrl: scoreboard bench for inst_fetch_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        br_valid;
  logic [31:0] br_target;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        ds_ready;

  inst_fetch_ctrl #(.RESET_PC(32'hBFC00000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .br_valid(br_valid), .br_target(br_target),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .ds_ready(ds_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] acc_log[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mem_en   = 0;
  bit          mon_en   = 0;
  bit          pend     = 0;
  logic [31:0] pend_addr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  function automatic void expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    sbq.push_back(e);
  endfunction

  // Memory responder: accepts whenever enabled, answers one cycle after accept.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        inst_data_ok = pend;
        inst_rdata   = pend ? mem_word(pend_addr) : 32'd0;
        pend         = 0;
        inst_addr_ok = 1'b1;
        if (inst_req) begin
          pend      = 1;
          pend_addr = inst_addr;
          acc_log.push_back(inst_addr);
        end
      end
    end
  end

  // Decode-side monitor: compares every popped head against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && resetn && fs_valid && ds_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pop got pc=%h inst=%h, required none", fs_pc, fs_inst);
        end else begin
          e = sbq.pop_front();
          if (fs_pc !== e.pc || fs_inst !== e.inst) begin
            failures++;
            $display("FAIL fetch_stream got pc=%h inst=%h, required pc=%h inst=%h",
                     fs_pc, fs_inst, e.pc, e.inst);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    mem_en = 0; mon_en = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    br_valid = 0; br_target = 0; ds_ready = 0;
    resetn = 0;
    sbq.delete();
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic enable_mem();
    @(posedge clk);
    #1;
    pend = 0;
    acc_log.delete();
    mem_en = 1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #4;
    end
    mon_en = 0;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d entries left, required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    resetn = 0; mem_en = 0; mon_en = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    br_valid = 0; br_target = 0; ds_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (inst_req !== 1'b0 || fs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got req=%b fs_valid=%b, required 0 0", inst_req, fs_valid);
    end
    checks++;
    if (fs_pc !== 32'd0 || fs_inst !== 32'd0) begin
      failures++;
      $display("FAIL reset_head got pc=%h inst=%h, required 0 0", fs_pc, fs_inst);
    end
    checks++;
    if (inst_addr !== 32'hBFC00000) begin
      failures++;
      $display("FAIL reset_addr got %h, required bfc00000", inst_addr);
    end
    checks++;
    if (inst_wr !== 1'b0 || inst_size !== 2'b10 || inst_wdata !== 32'd0) begin
      failures++;
      $display("FAIL const_outputs got wr=%b size=%b wdata=%h, required 0 10 0",
               inst_wr, inst_size, inst_wdata);
    end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h, required 1 bfc00000", inst_req, inst_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    ds_ready = 1;
    for (int i = 0; i < 6; i++) expect_pc(32'hBFC00000 + 32'(4 * i));
    mon_en = 1;
    enable_mem();
    wait_drain("sequential");
  endtask

  task automatic test_backpressure();
    do_reset();
    ds_ready = 0;
    for (int i = 0; i < 5; i++) expect_pc(32'hBFC00000 + 32'(4 * i));
    mon_en = 1;
    enable_mem();
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (fs_valid !== 1'b1 || inst_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got fs_valid=%b req=%b, required 1 0", fs_valid, inst_req);
    end
    checks++;
    if (acc_log.size() != 2) begin
      failures++;
      $display("FAIL bp_accepts got %0d, required 2", acc_log.size());
    end
    checks++;
    if (fs_pc !== 32'hBFC00000 || fs_inst !== mem_word(32'hBFC00000)) begin
      failures++;
      $display("FAIL bp_head got pc=%h inst=%h, required bfc00000 %h",
               fs_pc, fs_inst, mem_word(32'hBFC00000));
    end
    ds_ready = 1;
    wait_drain("backpressure");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= acc_log.size() || acc_log[i] !== 32'hBFC00000 + 32'(4 * i)) begin
        failures++;
        $display("FAIL bp_accept_seq index %0d wrong or missing, required %h",
                 i, 32'hBFC00000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    ds_ready = 1;
    expect_pc(32'h80001000);
    expect_pc(32'h80001004);
    mon_en = 1;
    @(negedge clk);
    inst_addr_ok = 1;
    @(negedge clk);
    inst_addr_ok = 0; br_valid = 1; br_target = 32'h80001003;
    #1;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++;
      $display("FAIL brw_in_wait got req=%b, required 0", inst_req);
    end
    @(negedge clk);
    br_valid = 0; inst_data_ok = 1; inst_rdata = 32'hDEADBEEF;
    @(negedge clk);
    inst_data_ok = 0;
    #1;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h80001000) begin
      failures++;
      $display("FAIL brw_redirect got fs_valid=%b req=%b addr=%h, required 0 1 80001000",
               fs_valid, inst_req, inst_addr);
    end
    enable_mem();
    wait_drain("branch_wait");
  endtask

  task automatic test_branch_addr_ok();
    do_reset();
    ds_ready = 1;
    expect_pc(32'h00002000);
    expect_pc(32'h00002004);
    mon_en = 1;
    @(negedge clk);
    inst_addr_ok = 1; br_valid = 1; br_target = 32'h00002000;
    @(negedge clk);
    inst_addr_ok = 0; br_valid = 0; inst_data_ok = 1; inst_rdata = 32'hBAD00001;
    #1;
    checks++;
    if (inst_req !== 1'b0 || inst_addr !== 32'h00002000) begin
      failures++;
      $display("FAIL bra_wait got req=%b addr=%h, required 0 00002000", inst_req, inst_addr);
    end
    @(negedge clk);
    inst_data_ok = 0;
    #1;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1) begin
      failures++;
      $display("FAIL bra_dropped got fs_valid=%b req=%b, required 0 1", fs_valid, inst_req);
    end
    enable_mem();
    wait_drain("branch_addr_ok");
    checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h00002000) begin
      failures++;
      $display("FAIL bra_next_addr got %h, required 00002000",
               acc_log.size() != 0 ? acc_log[0] : 32'hFFFFFFFF);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ds_ready = 1;
    expect_pc(32'h12345678);
    expect_pc(32'h1234567C);
    mon_en = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got req=%b addr=%h, required 1 bfc00000",
                 i, inst_req, inst_addr);
      end
    end
    @(negedge clk);
    br_valid = 1; br_target = 32'h1234567B;
    @(negedge clk);
    br_valid = 0;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h12345678) begin
      failures++;
      $display("FAIL stall_redirect got req=%b addr=%h, required 1 12345678", inst_req, inst_addr);
    end
    enable_mem();
    wait_drain("stall");
  endtask

  task automatic test_wrap();
    do_reset();
    ds_ready = 1;
    expect_pc(32'hFFFFFFF8);
    expect_pc(32'hFFFFFFFC);
    expect_pc(32'h00000000);
    mon_en = 1;
    @(negedge clk);
    br_valid = 1; br_target = 32'hFFFFFFF8;
    @(negedge clk);
    br_valid = 0;
    enable_mem();
    wait_drain("wrap");
  endtask

  task automatic test_branch_pop();
    do_reset();
    ds_ready = 0;
    expect_pc(32'hBFC00000);
    expect_pc(32'h00000400);
    expect_pc(32'h00000404);
    mon_en = 1;
    enable_mem();
    repeat (12) @(negedge clk);
    ds_ready = 1; br_valid = 1; br_target = 32'h00000403;
    @(negedge clk);
    br_valid = 0;
    #1;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h00000400) begin
      failures++;
      $display("FAIL brpop_flush got fs_valid=%b req=%b addr=%h, required 0 1 00000400",
               fs_valid, inst_req, inst_addr);
    end
    wait_drain("branch_pop");
  endtask

  task automatic test_reset_midreq();
    do_reset();
    ds_ready = 1;
    @(negedge clk);
    inst_addr_ok = 1;
    @(negedge clk);
    inst_addr_ok = 0;
    #1;
    checks++;
    if (inst_req !== 1'b0 || inst_addr !== 32'hBFC00004) begin
      failures++;
      $display("FAIL mid_wait got req=%b addr=%h, required 0 bfc00004", inst_req, inst_addr);
    end
    #2;
    resetn = 0;
    #1;
    checks++;
    if (inst_addr !== 32'hBFC00000 || fs_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got addr=%h fs_valid=%b, required bfc00000 0", inst_addr, fs_valid);
    end
    @(negedge clk);
    resetn = 1; inst_data_ok = 1; inst_rdata = 32'hBAD00002;
    @(negedge clk);
    inst_data_ok = 0;
    #1;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
      failures++;
      $display("FAIL stray_data got fs_valid=%b req=%b addr=%h, required 0 1 bfc00000",
               fs_valid, inst_req, inst_addr);
    end
    expect_pc(32'hBFC00000);
    expect_pc(32'hBFC00004);
    mon_en = 1;
    enable_mem();
    wait_drain("reset_midreq");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_wait();
    test_branch_addr_ok();
    test_stall();
    test_wrap();
    test_branch_pop();
    test_reset_midreq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, SHALL be the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, fixed at 2, SHALL be the depth of the fetched-instruction buffer toward decode.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 inst_req  out  1  sram-like request valid.
REQ-006 inst_wr  out  1  constant 0.
REQ-007 inst_size  out  2  constant 2'b10 (word).
REQ-008 inst_addr  out  32  fetch address, bits [1:0] always 2'b00.
REQ-009 inst_wdata  out  32  constant 0.
REQ-010 inst_rdata  in  32  returned instruction, valid with inst_data_ok.
REQ-011 inst_addr_ok  in  1  address accepted when high together with inst_req.
REQ-012 inst_data_ok  in  1  one-cycle pulse: data for oldest accepted request.
REQ-013 br_valid  in  1  one-cycle redirect pulse.
REQ-014 br_target  in  32  redirect address; bits [1:0] ignored.
REQ-015 fs_valid  out  1  buffer head valid toward decode.
REQ-016 fs_pc  out  32  PC of buffer head.
REQ-017 fs_inst  out  32  instruction of buffer head.
REQ-018 ds_ready  in  1  decode accepts head when fs_valid & ds_ready.

Function
REQ-019 FSM states IDLE, REQ, WAIT; at most one request outstanding.
REQ-020 IDLE->REQ when (buffer count) < 2 after the same-cycle pop; inst_req high only in REQ.
REQ-021 REQ: inst_addr = pc; on inst_req & inst_addr_ok, latch req_pc = pc, pc += 4, go to WAIT.
REQ-022 WAIT: on inst_data_ok, push {req_pc, inst_rdata} unless cancelled; go to REQ if room remains after push/pop, else IDLE.
REQ-023 inst_data_ok outside WAIT SHALL be ignored.
REQ-024 Buffer: 2-entry FIFO, push and pop in the same cycle both take effect; push when full SHALL never occur (issue gated by REQ-020 counting the outstanding slot).
REQ-025 Issue gating: a new request SHALL only be issued if count + outstanding < 2.
REQ-026 br_valid: pc <= {br_target[31:2],2'b00}; buffer flushed (count 0) in the same edge; fs_valid low next cycle.
REQ-027 br_valid in REQ without addr_ok: stay in REQ; inst_addr shows new target next cycle.
REQ-028 br_valid in REQ with addr_ok same cycle: request counted accepted, go to WAIT with cancel=1; pc <= target (no +4).
REQ-029 br_valid in WAIT: set cancel=1; the returning data SHALL be discarded; cancel cleared on that data_ok.
REQ-030 br_valid coincident with inst_data_ok in WAIT: data discarded, next state REQ.
REQ-031 br_valid coincident with pop: flush dominates; pop has no further effect.
REQ-032 pc increment wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-033 fs_pc/fs_inst SHALL come directly from the FIFO head register, no combinational path from inst_rdata.

Reset
REQ-034 On resetn low (asynchronous): state IDLE, pc = RESET_PC, count 0, cancel 0, inst_req 0, fs_valid 0, fs_pc 0, fs_inst 0.
REQ-035 Reset asserted mid-request SHALL drop the transaction; a later inst_data_ok for it (state IDLE) is ignored.
REQ-036 First inst_req SHALL assert the first cycle after resetn deasserts.

Verification
REQ-037 Reset release, addr_ok=1 always, data_ok 1 cycle after accept, ds_ready=1 -> fs_pc sequence BFC00000, BFC00004, BFC00008, instructions match memory.
REQ-038 ds_ready=0 -> exactly 2 entries buffered, inst_req stays low; ds_ready=1 -> fetch resumes at next sequential PC, no duplication/loss.
REQ-039 br_valid, target 32'h80001003, during WAIT -> returned data dropped, next fs_pc 32'h80001000.
REQ-040 br_valid same cycle as addr_ok -> that response dropped; next accepted inst_addr = target.
REQ-041 addr_ok held low 5 cycles -> inst_req and inst_addr stable; br_valid mid-stall -> inst_addr switches to target next cycle.
REQ-042 resetn asserted while in WAIT, stray data_ok after release -> no fs_valid, fetch restarts at BFC00000.
